// File: rtl/udp_pkt_fifo_pkg.sv
// Shared sizing helpers for the packet FIFO: pointer width, depth and
// watermark thresholds derived from the address width.
package udp_pkt_fifo_pkg;

   localparam int unsigned PTR_EXTRA_BITS = 1;

   function automatic int unsigned ptr_width(input int unsigned aw);
      return aw + PTR_EXTRA_BITS;
   endfunction

   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   function automatic int unsigned af_threshold(input int unsigned aw, input int unsigned free_num);
      return fifo_depth(aw) - free_num;
   endfunction

endpackage

// File: rtl/udp_pkt_fifo_ram.sv
// Distributed simple dual-port RAM: synchronous write, asynchronous read.
module udp_pkt_fifo_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 33
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/udp_pkt_sync_fifo.sv
// Single-clock packet FIFO: words become readable only once their packet is
// committed by wr_last; wr_drop rewinds the speculative write pointer.
module udp_pkt_sync_fifo
   import udp_pkt_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = 10,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned OUT_REG          = 0,
   parameter int unsigned ALMOST_FULL_NUM  = 4,
   parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  wr_last,
   input  logic                  wr_drop,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_water_level,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_water_level,
   output logic [ADDR_WIDTH:0]   pkt_cnt,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int unsigned PW = ptr_width(ADDR_WIDTH);
   localparam logic [PW-1:0] DEPTH_P   = PW'(fifo_depth(ADDR_WIDTH));
   localparam logic [PW-1:0] AF_THRESH = PW'(af_threshold(ADDR_WIDTH, ALMOST_FULL_NUM));
   localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_NUM);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic [PW-1:0]       wr_level, rd_level;
   logic                wr_accept, rd_accept, commit, pkt_read;
   logic [DATA_WIDTH:0] head_word;

   assign wr_level  = wr_ptr_q - rd_ptr_q;
   assign rd_level  = cmt_ptr_q - rd_ptr_q;
   assign full      = (wr_level == DEPTH_P);
   assign empty     = (cmt_ptr_q == rd_ptr_q);
   assign wr_accept = wr_en & ~full & ~wr_drop;
   assign rd_accept = rd_en & ~empty;
   assign commit    = wr_accept & wr_last;
   assign pkt_read  = rd_accept & head_word[DATA_WIDTH];

   udp_pkt_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH + 1)
   ) u_ram (
      .clk   (clk),
      .we    (wr_accept),
      .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata ({wr_last, wr_data}),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (head_word)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      cmt_ptr_d   = cmt_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pkt_cnt_d   = pkt_cnt_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      // Drop rewinds to the last commit point; any write that cycle is already gated off.
      if (wr_drop) begin
         wr_ptr_d = cmt_ptr_q;
      end else if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (commit) begin
         cmt_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({commit, pkt_read})
         2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
         2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en & full & ~wr_drop) begin
         overflow_d = 1'b1;
      end
      if (rd_en & empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         cmt_ptr_q   <= '0;
         rd_ptr_q    <= '0;
         pkt_cnt_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         cmt_ptr_q   <= cmt_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pkt_cnt_q   <= pkt_cnt_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                  rd_last_q, rd_last_d;

         always_comb begin
            rd_data_d = rd_data_q;
            rd_last_d = rd_last_q;
            if (rd_accept) begin
               rd_data_d = head_word[DATA_WIDTH-1:0];
               rd_last_d = head_word[DATA_WIDTH];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_q <= '0;
               rd_last_q <= 1'b0;
            end else begin
               rd_data_q <= rd_data_d;
               rd_last_q <= rd_last_d;
            end
         end

         assign rd_data = rd_data_q;
         assign rd_last = rd_last_q;
      end else begin : g_show_ahead
         assign rd_data = head_word[DATA_WIDTH-1:0];
         assign rd_last = head_word[DATA_WIDTH];
      end
   endgenerate

   assign wr_water_level = wr_level;
   assign rd_water_level = rd_level;
   assign almost_full    = (wr_level >= AF_THRESH);
   assign almost_empty   = (rd_level <= AE_THRESH);
   assign pkt_cnt        = pkt_cnt_q;
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;

endmodule

// File: tb/tb_udp_pkt_sync_fifo.sv
// Directed and scoreboarded checks of udp_pkt_sync_fifo (16-deep, 8-bit, show-ahead).
module tb_udp_pkt_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_en = 1'b0, wr_last = 1'b0, wr_drop = 1'b0;
   logic       rd_en = 1'b0, err_clr = 1'b0;
   logic       full, almost_full, rd_last, empty, almost_empty, overflow, underflow;
   logic [7:0] rd_data;
   logic [4:0] wr_water_level, rd_water_level, pkt_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [8:0] exp_q[$];
   logic [8:0] pend_q[$];

   always #5 clk = ~clk;

   udp_pkt_sync_fifo #(
      .ADDR_WIDTH       (4),
      .DATA_WIDTH       (8),
      .OUT_REG          (0),
      .ALMOST_FULL_NUM  (4),
      .ALMOST_EMPTY_NUM (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_last        (wr_last),
      .wr_drop        (wr_drop),
      .full           (full),
      .almost_full    (almost_full),
      .wr_water_level (wr_water_level),
      .rd_data        (rd_data),
      .rd_last        (rd_last),
      .rd_en          (rd_en),
      .empty          (empty),
      .almost_empty   (almost_empty),
      .rd_water_level (rd_water_level),
      .pkt_cnt        (pkt_cnt),
      .overflow       (overflow),
      .underflow      (underflow),
      .err_clr        (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, pass the edge, then release them 1ns later.
   task automatic cyc(input logic we, input logic [7:0] wd, input logic wl,
                      input logic wdrop, input logic re, input logic eclr);
      wr_en = we; wr_data = wd; wr_last = wl; wr_drop = wdrop; rd_en = re; err_clr = eclr;
      @(posedge clk);
      #1;
      wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_afull"}, 32'(almost_full), 32'd0);
      check({tag, "_wrlvl"}, 32'(wr_water_level), 32'd0);
      check({tag, "_rdlvl"}, 32'(rd_water_level), 32'd0);
      check({tag, "_pktcnt"}, 32'(pkt_cnt), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_udf"}, 32'(underflow), 32'd0);
   endtask

   task automatic read_expect(input string tag, input logic [7:0] d, input logic l);
      check({tag, "_data"}, 32'(rd_data), 32'(d));
      check({tag, "_last"}, 32'(rd_last), 32'(l));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic model_read();
      check("rnd_data", 32'(rd_data), 32'(exp_q[0][7:0]));
      check("rnd_last", 32'(rd_last), 32'(exp_q[0][8]));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      void'(exp_q.pop_front());
   endtask

   function automatic int unsigned model_pkts();
      int unsigned n = 0;
      foreach (exp_q[i]) if (exp_q[i][8]) n++;
      return n;
   endfunction

   initial begin
      #12;
      check_reset_state("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three-word packet: invisible to the reader until committed.
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_empty_w1", 32'(empty), 32'd1);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_empty_w2", 32'(empty), 32'd1);
      cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t1_empty_w3", 32'(empty), 32'd0);
      check("t1_rdlvl", 32'(rd_water_level), 32'd3);
      check("t1_pktcnt", 32'(pkt_cnt), 32'd1);
      check("t1_aempty", 32'(almost_empty), 32'd1);
      read_expect("t1_r0", 8'h11, 1'b0);
      read_expect("t1_r1", 8'h22, 1'b0);
      check("t1_pktcnt_mid", 32'(pkt_cnt), 32'd1);
      read_expect("t1_r2", 8'h33, 1'b1);
      check("t1_pktcnt_end", 32'(pkt_cnt), 32'd0);
      check("t1_empty_end", 32'(empty), 32'd1);

      // Partial packet discarded by wr_drop; drop also beats a same-cycle write.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_wrlvl_pre", 32'(wr_water_level), 32'd5);
      check("t2_empty_pre", 32'(empty), 32'd1);
      cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t2_wrlvl_drop", 32'(wr_water_level), 32'd0);
      check("t2_empty_drop", 32'(empty), 32'd1);
      check("t2_pktcnt_drop", 32'(pkt_cnt), 32'd0);
      cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2_rdlvl", 32'(rd_water_level), 32'd2);
      read_expect("t2_r0", 8'hA1, 1'b0);
      read_expect("t2_r1", 8'hA2, 1'b1);

      // Fill to depth, overflow, clear; then read+write together at full.
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), (i == 15), 1'b0, 1'b0, 1'b0);
      check("t3_full", 32'(full), 32'd1);
      check("t3_afull", 32'(almost_full), 32'd1);
      check("t3_aempty", 32'(almost_empty), 32'd0);
      check("t3_wrlvl", 32'(wr_water_level), 32'd16);
      check("t3_ovf_pre", 32'(overflow), 32'd0);
      cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t3_ovf", 32'(overflow), 32'd1);
      check("t3_wrlvl_ovf", 32'(wr_water_level), 32'd16);
      check("t3_pktcnt_ovf", 32'(pkt_cnt), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_ovf_clr", 32'(overflow), 32'd0);
      check("t3_head", 32'(rd_data), 32'h40);
      cyc(1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t3_rw_wrlvl", 32'(wr_water_level), 32'd15);
      check("t3_rw_rdlvl", 32'(rd_water_level), 32'd15);
      check("t3_rw_full", 32'(full), 32'd0);
      check("t3_rw_ovf", 32'(overflow), 32'd1);
      check("t3_rw_afull", 32'(almost_full), 32'd1);
      for (int i = 1; i < 16; i++) read_expect("t3_drain", 8'(8'h40 + i), (i == 15));
      check("t3_pktcnt_end", 32'(pkt_cnt), 32'd0);
      check("t3_empty_end", 32'(empty), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

      // Underflow on empty, set beats same-cycle clear, pointer not disturbed.
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t4_udf", 32'(underflow), 32'd1);
      check("t4_rdlvl", 32'(rd_water_level), 32'd0);
      check("t4_wrlvl", 32'(wr_water_level), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t4_udf_setwins", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t4_udf_clr", 32'(underflow), 32'd0);
      cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      read_expect("t4_after", 8'h5A, 1'b1);

      // 40 random packets, some dropped, with interleaved reads across pointer wrap.
      for (int p = 0; p < 40; p++) begin
         int unsigned len;
         logic        drop_pkt;
         len      = $urandom_range(1, 5);
         drop_pkt = ($urandom_range(0, 3) == 0);
         while (exp_q.size() + len > 16) model_read();
         for (int i = 0; i < int'(len); i++) begin
            logic       re, wl;
            logic [7:0] d;
            d  = 8'($urandom);
            wl = (i == int'(len) - 1) && !drop_pkt;
            re = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            if (re) begin
               check("rnd_data", 32'(rd_data), 32'(exp_q[0][7:0]));
               check("rnd_last", 32'(rd_last), 32'(exp_q[0][8]));
            end
            cyc(1'b1, d, wl, 1'b0, re, 1'b0);
            if (re) void'(exp_q.pop_front());
            pend_q.push_back({wl, d});
         end
         if (drop_pkt) cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
         else foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
         pend_q.delete();
         check("rnd_wrlvl", 32'(wr_water_level), 32'(exp_q.size()));
         check("rnd_rdlvl", 32'(rd_water_level), 32'(exp_q.size()));
         check("rnd_pktcnt", 32'(pkt_cnt), 32'(model_pkts()));
      end
      while (exp_q.size() > 0) model_read();
      check("rnd_empty", 32'(empty), 32'd1);
      check("rnd_ovf", 32'(overflow), 32'd0);
      check("rnd_udf", 32'(underflow), 32'd0);

      // Reset in the middle of a packet, with a committed packet also queued.
      cyc(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t6_udf_pre", 32'(underflow), 32'd1);
      check("t6_wrlvl_pre", 32'(wr_water_level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("t6");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t6_rdlvl_post", 32'(rd_water_level), 32'd1);
      read_expect("t6_post", 8'h77, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_pkt_sync_fifo.md
UDP_PKT_SYNC_FIFO -- requirements
Module: udp_pkt_sync_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 10, depth = 2**ADDR_WIDTH words, legal 4..10.
REQ-002 SHALL have parameter DATA_WIDTH, 32, payload width, legal 1..256.
REQ-003 SHALL have parameter OUT_REG, 0; 0 = show-ahead head word, 1 = registered read data.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, 4, free-word threshold for almost_full.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, 4, readable-word threshold for almost_empty.
REQ-006 SHALL have port clk  in  1  single clock for all logic.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports wr_data in DATA_WIDTH; wr_en in 1; wr_last in 1, marks final word of a packet; wr_drop in 1, discards the uncommitted packet.
REQ-009 SHALL have ports full out 1; almost_full out 1; wr_water_level out ADDR_WIDTH+1.
REQ-010 SHALL have ports rd_data out DATA_WIDTH; rd_last out 1; rd_en in 1; empty out 1; almost_empty out 1; rd_water_level out ADDR_WIDTH+1.
REQ-011 SHALL have ports pkt_cnt out ADDR_WIDTH+1; overflow out 1; underflow out 1; err_clr in 1.

Function
REQ-012 SHALL keep three ADDR_WIDTH+1-bit pointers: wr_ptr (speculative), cmt_ptr (committed), rd_ptr; addresses are the low ADDR_WIDTH bits; wrap is natural modulo 2**(ADDR_WIDTH+1).
REQ-013 SHALL store {wr_last, wr_data} at wr_ptr and increment wr_ptr when wr_en & ~full & ~wr_drop.
REQ-014 SHALL set cmt_ptr to the incremented wr_ptr on an accepted write with wr_last = 1.
REQ-015 SHALL, on wr_drop = 1, load wr_ptr with cmt_ptr the next cycle and discard any write in that cycle (drop wins over wr_en and wr_last).
REQ-016 SHALL define full = (wr_ptr - rd_ptr == 2**ADDR_WIDTH), empty = (cmt_ptr == rd_ptr); uncommitted words are never readable.
REQ-017 SHALL advance rd_ptr on rd_en & ~empty; with OUT_REG = 0, rd_data/rd_last show the head word combinationally; with OUT_REG = 1, they update one cycle after the accepted read and hold otherwise.
REQ-018 SHALL output wr_water_level = wr_ptr - rd_ptr and rd_water_level = cmt_ptr - rd_ptr, both from registered pointers.
REQ-019 SHALL assert almost_full when wr_water_level >= 2**ADDR_WIDTH - ALMOST_FULL_NUM and almost_empty when rd_water_level <= ALMOST_EMPTY_NUM.
REQ-020 SHALL increment pkt_cnt on commit, decrement it on an accepted read of a word with last = 1, and hold it when both occur in one cycle.
REQ-021 SHALL set sticky overflow on wr_en & full & ~wr_drop and sticky underflow on rd_en & empty; err_clr clears both, with a same-cycle set winning.
REQ-022 SHALL allow simultaneous write and read in one cycle, including at full (write refused, read accepted) and at empty (read refused).
REQ-023 SHALL never let a single packet exceed depth: when full occurs mid-packet, the writer issues wr_drop; the FIFO SHALL NOT self-drop.

Reset
REQ-024 SHALL, on rst_n low, clear all pointers, pkt_cnt, overflow, underflow and the OUT_REG=1 output register to 0, giving empty = 1, almost_empty = 1, full = 0, almost_full = 0, water levels = 0.
REQ-025 SHALL NOT reset storage contents; a mid-packet reset discards all committed and uncommitted data.

Structure
REQ-026 SHALL place pointer-width and threshold helper constants in package udp_pkt_fifo_pkg.
REQ-027 SHALL instantiate one sub-module, udp_pkt_fifo_ram: a distributed simple dual-port RAM, DATA_WIDTH+1 wide, with synchronous write and asynchronous read.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, OUT_REG=0)
REQ-028 SHALL write 3 words 0x11,0x22,0x33 with last on 0x33 -> empty stays 1 until the cycle after 0x33, then rd_water_level=3, pkt_cnt=1; reads return 0x11,0x22,0x33 with rd_last only on 0x33 and pkt_cnt=0.
REQ-029 SHALL write 5 words without last, then pulse wr_drop -> wr_water_level returns to 0, empty remains 1, and a following 2-word packet reads back intact.
REQ-030 SHALL fill 16 words as one packet, then write again -> full=1, overflow=1, wr_water_level=16; err_clr -> overflow=0.
REQ-031 SHALL read on an empty FIFO -> underflow=1, rd_ptr unchanged; at full, simultaneous wr_en and rd_en -> the read is accepted, the write is refused, and the level becomes 15.
REQ-032 SHALL run 40 random commit/drop packets with pointer wrap and compare against a scoreboard; also assert rst_n mid-packet -> all outputs take their REQ-024 reset values.
